// File: rtl/clmul_karatsuba_seq.sv
// Sequential carry-less multiplier: one-level Karatsuba over a shared half-width
// multiplier, with optional reduction modulo x^WIDTH + POLY.
module clmul_karatsuba_seq #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 'h1B
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod
);
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [2:0] {IDLE, M0, M1, M2, CMB, RED, OUT} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0] a_r, b_r;
    logic             mode_r;
    logic [WIDTH-1:0] d0, d1, d2;
    logic [W2-1:0]    prod_r;

    logic [H-1:0]     mul_x, mul_y;
    logic [WIDTH-1:0] mul_p;
    logic [WIDTH-1:0] d7;
    logic [W2-1:0]    combined;
    logic [W2-1:0]    red_acc;
    logic [W2-1:0]    reduced;
    logic [W2-1:0]    modulus;

    function automatic logic [WIDTH-1:0] clmul_half(input logic [H-1:0] x, input logic [H-1:0] y);
        logic [WIDTH-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < H; i++) begin
            if (y[i]) acc ^= {{H{1'b0}}, x} << i;
        end
        return acc;
    endfunction

    // The single half multiplier is time-shared; its operands follow the state.
    always_comb begin
        mul_x = a_r[WIDTH-1:H];
        mul_y = b_r[WIDTH-1:H];
        case (state)
            M0: begin
                mul_x = a_r[H-1:0];
                mul_y = b_r[H-1:0];
            end
            M1: begin
                mul_x = a_r[H-1:0] ^ a_r[WIDTH-1:H];
                mul_y = b_r[H-1:0] ^ b_r[WIDTH-1:H];
            end
            default: ;
        endcase
        mul_p = clmul_half(mul_x, mul_y);
    end

    always_comb begin
        d7       = d0 ^ d1 ^ d2;
        combined = {{WIDTH{1'b0}}, d0}
                 ^ ({{WIDTH{1'b0}}, d7} << H)
                 ^ {d2, {WIDTH{1'b0}}};
    end

    // Fold the high half down from the top bit; bit W2-1 of a clmul product is always 0.
    always_comb begin
        modulus = {{(WIDTH-1){1'b0}}, 1'b1, POLY};
        red_acc = prod_r;
        for (int unsigned k = 0; k < WIDTH - 1; k++) begin
            if (red_acc[W2-2-k]) red_acc ^= modulus << (WIDTH - 2 - k);
        end
        reduced = {{WIDTH{1'b0}}, red_acc[WIDTH-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = M0;
            M0:   state_next = M1;
            M1:   state_next = M2;
            M2:   state_next = CMB;
            CMB:  state_next = mode_r ? RED : OUT;
            RED:  state_next = OUT;
            OUT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= 1'b0;
            d0     <= '0;
            d1     <= '0;
            d2     <= '0;
            prod_r <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r    <= a;
                    b_r    <= b;
                    mode_r <= mode;
                end
                M0:  d0     <= mul_p;
                M1:  d1     <= mul_p;
                M2:  d2     <= mul_p;
                CMB: prod_r <= combined;
                RED: prod_r <= reduced;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign prod      = prod_r;
endmodule

// File: tb/tb_clmul_karatsuba_seq.sv
// Directed checks on an 8-bit instance plus a 16-bit instance checked against
// a shift-XOR / xtime reference.
module tb_clmul_karatsuba_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;
    logic        in_valid16, in_ready16, mode16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    clmul_karatsuba_seq #(.WIDTH(8), .POLY(8'h1B)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8),
        .out_ready(out_ready8), .prod(prod8)
    );

    clmul_karatsuba_seq #(.WIDTH(16), .POLY(16'h002B)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .mode(mode16), .out_valid(out_valid16),
        .out_ready(out_ready16), .prod(prod16)
    );

    function automatic logic [31:0] ref_raw16(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) if (y[i]) acc ^= {16'h0, x} << i;
        return acc;
    endfunction

    function automatic logic [31:0] ref_red16(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] acc, s;
        acc = '0;
        s   = x;
        for (int i = 0; i < 16; i++) begin
            if (y[i]) acc ^= s;
            s = s[15] ? ((s << 1) ^ 16'h002B) : (s << 1);
        end
        return {16'h0, acc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one 8-bit operand pair, scramble inputs afterwards, wait for out_valid.
    task automatic txn8(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                        output logic [15:0] p, output int lat);
        int n;
        a8 = ta; b8 = tb; mode8 = tm; in_valid8 = 1'b1;
        n = 0;
        while (!in_ready8 && n < 20) begin step(); n++; end
        step();
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); mode8 = ~tm;
        lat = 0;
        while (!out_valid8 && lat < 20) begin step(); lat++; end
        p = prod8;
    endtask

    task automatic release8();
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        total += 6;
        if (in_ready8 !== 1'b1)  begin bad++; $display("FAIL reset_in_ready8 got=%b exp=1", in_ready8); end
        if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid8 got=%b exp=0", out_valid8); end
        if (prod8 !== 16'h0)     begin bad++; $display("FAIL reset_prod8 got=%h exp=0", prod8); end
        if (in_ready16 !== 1'b1) begin bad++; $display("FAIL reset_in_ready16 got=%b exp=1", in_ready16); end
        if (out_valid16 !== 1'b0) begin bad++; $display("FAIL reset_out_valid16 got=%b exp=0", out_valid16); end
        if (prod16 !== 32'h0)    begin bad++; $display("FAIL reset_prod16 got=%h exp=0", prod16); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_raw();
        logic [15:0] p; int lat;
        txn8(8'h53, 8'hCA, 1'b0, p, lat);
        total += 2;
        if (p !== 16'h3F7E) begin bad++; $display("FAIL raw_prod got=%h exp=3f7e", p); end
        if (lat !== 4)      begin bad++; $display("FAIL raw_latency got=%0d exp=4", lat); end
        release8();
        total++;
        if (in_ready8 !== 1'b1) begin bad++; $display("FAIL raw_return_idle got=%b exp=1", in_ready8); end
    endtask

    task automatic test_reduced();
        logic [15:0] p; int lat;
        txn8(8'h53, 8'hCA, 1'b1, p, lat);
        total += 2;
        if (p !== 16'h0001) begin bad++; $display("FAIL red_prod got=%h exp=0001", p); end
        if (lat !== 5)      begin bad++; $display("FAIL red_latency got=%0d exp=5", lat); end
        release8();
    endtask

    task automatic test_square();
        logic [15:0] p; int lat;
        txn8(8'hFF, 8'hFF, 1'b0, p, lat);
        total += 2;
        if (p !== 16'h5555) begin bad++; $display("FAIL square_prod got=%h exp=5555", p); end
        if (lat !== 4)      begin bad++; $display("FAIL square_latency got=%0d exp=4", lat); end
        release8();
    endtask

    task automatic test_zero();
        logic [15:0] p; int lat;
        for (int m = 0; m < 2; m++) begin
            txn8(8'h00, 8'hA7, m[0], p, lat);
            total++;
            if (p !== 16'h0) begin bad++; $display("FAIL zero_prod mode=%0d got=%h exp=0", m, p); end
            release8();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] p; int lat;
        txn8(8'h53, 8'hCA, 1'b0, p, lat);
        total++;
        if (p !== 16'h3F7E) begin bad++; $display("FAIL bp_first got=%h exp=3f7e", p); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
            step();
            in_valid8 = 1'b0;
            total += 3;
            if (prod8 !== 16'h3F7E) begin bad++; $display("FAIL bp_stable cyc=%0d got=%h exp=3f7e", i, prod8); end
            if (in_ready8 !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready8); end
            if (out_valid8 !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid8); end
        end
        release8();
        total += 2;
        if (in_ready8 !== 1'b1)  begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready8); end
        if (out_valid8 !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid8); end
        txn8(8'h57, 8'h83, 1'b0, p, lat);
        total++;
        if (p !== 16'h2B79) begin bad++; $display("FAIL bp_second got=%h exp=2b79", p); end
        release8();
    endtask

    task automatic test_reset_mid();
        logic [15:0] p; int lat; int seen;
        a8 = 8'h53; b8 = 8'hCA; mode8 = 1'b0; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total += 3;
        if (in_ready8 !== 1'b1)  begin bad++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready8); end
        if (out_valid8 !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid8); end
        if (prod8 !== 16'h0)     begin bad++; $display("FAIL rmid_prod got=%h exp=0", prod8); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid8) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rmid_ghost_result got=%0d exp=0", seen); end
        txn8(8'h02, 8'h03, 1'b0, p, lat);
        total += 2;
        if (p !== 16'h0006) begin bad++; $display("FAIL rmid_after got=%h exp=0006", p); end
        if (lat !== 4)      begin bad++; $display("FAIL rmid_after_latency got=%0d exp=4", lat); end
        release8();
    endtask

    task automatic test_width16(input logic m);
        logic [31:0] exp; int n, lat;
        out_ready16 = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (k == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; end
            else begin a16 = 16'($urandom); b16 = 16'($urandom); end
            mode16 = m;
            exp = m ? ref_red16(a16, b16) : ref_raw16(a16, b16);
            in_valid16 = 1'b1;
            n = 0;
            while (!in_ready16 && n < 20) begin step(); n++; end
            step();
            in_valid16 = 1'b0;
            mode16 = ~m;
            lat = 0;
            while (!out_valid16 && lat < 20) begin step(); lat++; end
            total += 2;
            if (prod16 !== exp) begin bad++; $display("FAIL w16_prod mode=%0d a=%h b=%h got=%h exp=%h", m, a16, b16, prod16, exp); end
            if (lat !== 4 + int'(m)) begin bad++; $display("FAIL w16_latency mode=%0d got=%0d exp=%0d", m, lat, 4 + int'(m)); end
            if (k == 0 && !m) begin
                total++;
                if (prod16 !== 32'h5555_5555) begin bad++; $display("FAIL w16_square got=%h exp=55555555", prod16); end
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp; int n, lat;
        int unsigned acc_cyc, prev_cyc;
        logic prev_m;
        out_ready16 = 1'b1;
        prev_cyc = 0; prev_m = 1'b0;
        for (int k = 0; k < 20; k++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); mode16 = k[0];
            exp = mode16 ? ref_red16(a16, b16) : ref_raw16(a16, b16);
            in_valid16 = 1'b1;
            n = 0;
            while (!in_ready16 && n < 20) begin step(); n++; end
            step();
            acc_cyc = cyc;
            in_valid16 = 1'b0;
            lat = 0;
            while (!out_valid16 && lat < 20) begin step(); lat++; end
            total++;
            if (prod16 !== exp) begin bad++; $display("FAIL b2b_prod k=%0d got=%h exp=%h", k, prod16, exp); end
            if (k > 0) begin
                total++;
                if (acc_cyc - prev_cyc !== 6 + 32'(prev_m)) begin
                    bad++;
                    $display("FAIL b2b_interval k=%0d got=%0d exp=%0d", k, acc_cyc - prev_cyc, 6 + int'(prev_m));
                end
            end
            prev_cyc = acc_cyc;
            prev_m = k[0];
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0;
        #1;
        test_reset();
        test_raw();
        test_reduced();
        test_square();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_width16(1'b0);
        test_width16(1'b1);
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
